// File: rtl/lsu.sv
// lsu -- single-outstanding load/store unit between the decoder and memory.
//
// Accepts one decoded memory op (in_valid/in_ready), issues it on a
// valid/ready request channel, waits for the read data or write acknowledge
// on a valid-only response channel, and then holds the writeback result
// (out_valid/out_ready) until it is taken.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        op handshake (in_ready high only in IDLE)
//   in_mem_wen, in_func3     store select, access size/sign
//   in_wmask[3:0]            byte mask before lane shifting
//   in_addr, in_wdata, in_rd effective address, LSB-aligned store data, dest reg
//   mem_req_*                word-aligned request with lane-shifted data/strobe
//   mem_resp_valid/_rdata    read data or write acknowledge
//   out_valid/out_ready      writeback handshake
//   out_rdata, out_rd, out_wen  extended load data, dest reg, reg write enable
//   busy                     FSM not in IDLE
//   out_err                  (LSU_MISALIGN_CHK_EN only) misaligned access flag
//
// Build option: define LSU_MISALIGN_CHK_EN to trap misaligned halfword/word
// accesses without touching memory.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_wen,
  input  logic [2:0]        in_func3,
  input  logic [7:0]        in_wmask,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              busy
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic              out_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state, state_nxt;

  logic              wen_q;
  logic [2:0]        f3_q;
  logic [3:0]        wmask_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              mis_in;
  logic [7:0]        wmask_sh;

  // Only the low four mask bits describe byte lanes of a 32-bit word.
  logic unused_wmask;
  assign unused_wmask = ^in_wmask[7:4];

  // Shift the raw word down to the addressed byte, then size/sign-extend.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  sh;
    sh = raw >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    return {{(DATA_W-8){b[7]}}, b};
      3'd4:    return {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'd1:    return {{(DATA_W-16){h[15]}}, h};
      3'd5:    return {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHK_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd1, 3'd5: return off[0];
      3'd2:       return off != 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  assign mis_in  = misaligned(in_func3, in_addr[1:0]);
  assign out_err = err_q;
`else
  assign mis_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        wen_q   <= in_mem_wen;
        f3_q    <= in_func3;
        wmask_q <= in_wmask[3:0];
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        rd_q    <= in_rd;
        rdata_q <= '0;
        err_q   <= mis_in;
      end
      // Responses are sampled only in RESP; anything arriving earlier is ignored.
      if (state == RESP && mem_resp_valid) begin
        rdata_q <= wen_q ? '0 : load_extend(f3_q, addr_q[1:0], mem_resp_rdata);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b1;
    out_wen       = 1'b0;
    wmask_sh      = {4'b0000, wmask_q} << addr_q[1:0];
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        // A trapped misaligned access never reaches memory.
        if (in_valid) state_nxt = mis_in ? DONE : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = RESP;
      end
      RESP: begin
        if (mem_resp_valid) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_wen   = ~wen_q & ~err_q;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields come straight from the latched op, so they stay stable in REQ;
  // lanes shifted past byte 3 fall off the top.
  assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_req_wmask = wen_q ? wmask_sh[3:0] : 4'b0000;
  assign out_rdata     = rdata_q;
  assign out_rd        = rd_q;

endmodule
